kmeans_centroid_update: RTL and testbench



---
 rtl/kmeans_pkg.sv | 25 ++
 rtl/kmeans_div.sv | 35 +++
 rtl/kmeans_centroid_update.sv | 111 +++++++++++
 tb/tb_kmeans_centroid_update.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kmeans_pkg.sv
// kmeans_pkg: constants, typedefs and helpers shared by the k-means datapath,
// the control FSM and the distance stage.
package kmeans_pkg;

    localparam int K  = 4;        // number of clusters (power of two)
    localparam int DW = 8;        // coordinate width per dimension
    localparam int N  = 128;      // points per iteration
    localparam int CW = 8;        // count width, holds N
    localparam int SW = DW + CW;  // sum width, cannot overflow for 2^CW-1 samples
    localparam int KW = $clog2(K);

    typedef logic [KW-1:0] cid_t;
    typedef logic [DW-1:0] coord_t;
    typedef logic [SW-1:0] sum_t;
    typedef logic [CW-1:0] cnt_t;

    // Largest per-axis movement that still counts as converged.
    localparam coord_t TH      = coord_t'(0);
    localparam cnt_t   CNT_MAX = '1;

    function automatic coord_t abs_diff(input coord_t a, input coord_t b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/kmeans_div.sv
// kmeans_div: combinational unsigned sum/count divider producing one centroid
// coordinate. A zero count yields 0; the caller keeps the old centroid then.
// Build option: KMEANS_ROUND_EN selects round-half-up instead of floor.
module kmeans_div
    import kmeans_pkg::*;
(
    input  logic [SW-1:0] num,
    input  logic [CW-1:0] den,
    output logic [DW-1:0] quo
);

    logic [SW:0] dividend;
    logic [SW:0] q_full;

    // Divide with optional half-count bias, then clamp into coordinate range.
    always_comb begin
        dividend = {1'b0, num};
`ifdef KMEANS_ROUND_EN
        dividend = dividend + (SW+1)'(den >> 1);
`endif
        if (den == '0) begin
            q_full = '0;
        end else begin
            q_full = dividend / (SW+1)'(den);
        end
        // With floor division the mean never exceeds the max coordinate, so
        // the clamp only matters for the rounded variant.
        if (q_full > (SW+1)'({DW{1'b1}})) begin
            quo = '1;
        end else begin
            quo = q_full[DW-1:0];
        end
    end

endmodule

// File: rtl/kmeans_centroid_update.sv
// kmeans_centroid_update: per-cluster sum/count accumulation, mean update,
// convergence flag and centroid registers for the k-means engine.
// Build option: KMEANS_ROUND_EN (round-half-up means, see kmeans_div).
module kmeans_centroid_update
    import kmeans_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            init_we,
    input  logic [KW-1:0]   init_idx,
    input  logic [DW-1:0]   init_x,
    input  logic [DW-1:0]   init_y,
    input  logic            valid,
    input  logic [DW-1:0]   px,
    input  logic [DW-1:0]   py,
    input  logic [KW-1:0]   cluster_id,
    input  logic            compute_mean,
    input  logic            clear_acc,
    output logic [K*DW-1:0] cx_flat,
    output logic [K*DW-1:0] cy_flat,
    output logic            converged,
    output logic [7:0]      iter_count,
    output logic            acc_ovf
);

    sum_t   sum_x [K];
    sum_t   sum_y [K];
    cnt_t   cnt   [K];
    coord_t cx    [K];
    coord_t cy    [K];

    coord_t qx    [K];
    coord_t qy    [K];
    coord_t nx    [K];
    coord_t ny    [K];
    logic   all_close;

    for (genvar g = 0; g < K; g++) begin : g_clu
        kmeans_div u_div_x (.num(sum_x[g]), .den(cnt[g]), .quo(qx[g]));
        kmeans_div u_div_y (.num(sum_y[g]), .den(cnt[g]), .quo(qy[g]));
        assign cx_flat[g*DW +: DW] = cx[g];
        assign cy_flat[g*DW +: DW] = cy[g];
    end

    // Candidate centroids (empty clusters keep theirs) and movement check.
    always_comb begin
        all_close = 1'b1;
        for (int i = 0; i < K; i++) begin
            nx[i] = (cnt[i] == '0) ? cx[i] : qx[i];
            ny[i] = (cnt[i] == '0) ? cy[i] : qy[i];
            if ((abs_diff(nx[i], cx[i]) > TH) || (abs_diff(ny[i], cy[i]) > TH)) begin
                all_close = 1'b0;
            end
        end
    end

    // Prioritised state update: rst > init_we > compute_mean > clear_acc > valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < K; i++) begin
                sum_x[i] <= '0;
                sum_y[i] <= '0;
                cnt[i]   <= '0;
                cx[i]    <= '0;
                cy[i]    <= '0;
            end
            converged  <= 1'b0;
            iter_count <= '0;
            acc_ovf    <= 1'b0;
        end else if (init_we) begin
            cx[init_idx] <= init_x;
            cy[init_idx] <= init_y;
            for (int i = 0; i < K; i++) begin
                sum_x[i] <= '0;
                sum_y[i] <= '0;
                cnt[i]   <= '0;
            end
            converged  <= 1'b0;
            iter_count <= '0;
            acc_ovf    <= 1'b0;
        end else if (compute_mean) begin
            // Accumulators are cleared here so the next iteration starts clean.
            for (int i = 0; i < K; i++) begin
                cx[i]    <= nx[i];
                cy[i]    <= ny[i];
                sum_x[i] <= '0;
                sum_y[i] <= '0;
                cnt[i]   <= '0;
            end
            converged <= all_close;
            if (iter_count != 8'hFF) begin
                iter_count <= iter_count + 8'd1;
            end
        end else if (clear_acc) begin
            for (int i = 0; i < K; i++) begin
                sum_x[i] <= '0;
                sum_y[i] <= '0;
                cnt[i]   <= '0;
            end
        end else if (valid) begin
            if (cnt[cluster_id] == CNT_MAX) begin
                acc_ovf <= 1'b1;
            end else begin
                sum_x[cluster_id] <= sum_x[cluster_id] + sum_t'(px);
                sum_y[cluster_id] <= sum_y[cluster_id] + sum_t'(py);
                cnt[cluster_id]   <= cnt[cluster_id] + cnt_t'(1);
            end
        end
    end

endmodule

// File: tb/tb_kmeans_centroid_update.sv
// Self-checking bench for kmeans_centroid_update with an integer reference
// model of the accumulate / mean / convergence rules.
module tb_kmeans_centroid_update;
    import kmeans_pkg::*;

    logic            clk = 1'b0;
    logic            rst, init_we, valid, compute_mean, clear_acc;
    logic [KW-1:0]   init_idx, cluster_id;
    logic [DW-1:0]   init_x, init_y, px, py;
    logic [K*DW-1:0] cx_flat, cy_flat;
    logic            converged, acc_ovf;
    logic [7:0]      iter_count;

    int checks = 0;
    int failures = 0;

    // Reference model state
    int m_cx [K], m_cy [K], m_sx [K], m_sy [K], m_cnt [K];
    int m_conv, m_iter, m_ovf;

    kmeans_centroid_update dut (
        .clk(clk), .rst(rst), .init_we(init_we), .init_idx(init_idx),
        .init_x(init_x), .init_y(init_y), .valid(valid), .px(px), .py(py),
        .cluster_id(cluster_id), .compute_mean(compute_mean), .clear_acc(clear_acc),
        .cx_flat(cx_flat), .cy_flat(cy_flat), .converged(converged),
        .iter_count(iter_count), .acc_ovf(acc_ovf)
    );

    always #5 clk = ~clk;

    function automatic int mean(input int s, input int c);
        int r;
`ifdef KMEANS_ROUND_EN
        r = (s + c / 2) / c;
        if (r > 255) r = 255;
`else
        r = s / c;
`endif
        return r;
    endfunction

    function logic [K*DW-1:0] exp_cx();
        logic [K*DW-1:0] v;
        for (int i = 0; i < K; i++) v[i*DW +: DW] = DW'(m_cx[i]);
        return v;
    endfunction

    function logic [K*DW-1:0] exp_cy();
        logic [K*DW-1:0] v;
        for (int i = 0; i < K; i++) v[i*DW +: DW] = DW'(m_cy[i]);
        return v;
    endfunction

    task automatic clear_model_acc();
        for (int i = 0; i < K; i++) begin
            m_sx[i] = 0; m_sy[i] = 0; m_cnt[i] = 0;
        end
    endtask

    // Apply the currently driven inputs to the model, as the spec rules say.
    task automatic model_update();
        if (rst) begin
            clear_model_acc();
            for (int i = 0; i < K; i++) begin m_cx[i] = 0; m_cy[i] = 0; end
            m_conv = 0; m_iter = 0; m_ovf = 0;
        end else if (init_we) begin
            m_cx[init_idx] = init_x; m_cy[init_idx] = init_y;
            clear_model_acc();
            m_conv = 0; m_iter = 0; m_ovf = 0;
        end else if (compute_mean) begin
            m_conv = 1;
            for (int i = 0; i < K; i++) begin
                if (m_cnt[i] != 0) begin
                    int nx, ny, dx, dy;
                    nx = mean(m_sx[i], m_cnt[i]);
                    ny = mean(m_sy[i], m_cnt[i]);
                    dx = nx - m_cx[i]; if (dx < 0) dx = -dx;
                    dy = ny - m_cy[i]; if (dy < 0) dy = -dy;
                    if (dx > TH || dy > TH) m_conv = 0;
                    m_cx[i] = nx; m_cy[i] = ny;
                end
            end
            clear_model_acc();
            if (m_iter < 255) m_iter++;
        end else if (clear_acc) begin
            clear_model_acc();
        end else if (valid) begin
            if (m_cnt[cluster_id] == 255) m_ovf = 1;
            else begin
                m_sx[cluster_id] += px; m_sy[cluster_id] += py; m_cnt[cluster_id]++;
            end
        end
    endtask

    // One clock: inputs were set before the edge, outputs examined at negedge.
    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
        rst = 0; init_we = 0; valid = 0; compute_mean = 0; clear_acc = 0;
    endtask

    task automatic do_init(input int idx, input int x, input int y);
        init_we = 1; init_idx = KW'(idx); init_x = DW'(x); init_y = DW'(y);
        tick();
    endtask

    task automatic do_sample(input int x, input int y, input int id);
        valid = 1; px = DW'(x); py = DW'(y); cluster_id = KW'(id);
        tick();
    endtask

    task automatic do_compute();
        compute_mean = 1;
        tick();
    endtask

    task automatic test_reset();
        rst = 1;
        tick();
        checks++;
        if (cx_flat !== '0 || cy_flat !== '0) begin
            failures++; $display("FAIL reset_centroids got cx=%h cy=%h exp 0", cx_flat, cy_flat);
        end
        checks++;
        if (converged !== 1'b0 || iter_count !== 8'd0 || acc_ovf !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags got conv=%b iter=%0d ovf=%b exp 0/0/0", converged, iter_count, acc_ovf);
        end
    endtask

    task automatic test_basic();
        do_init(0, 10, 10); do_init(1, 200, 200); do_init(2, 50, 60); do_init(3, 90, 30);
        for (int pass = 1; pass <= 2; pass++) begin
            do_sample(8, 12, 0); do_sample(12, 8, 0); do_sample(198, 202, 1);
            do_compute();
            checks++;
            if (cx_flat[0 +: DW] !== 8'd10 || cy_flat[0 +: DW] !== 8'd10 ||
                cx_flat[DW +: DW] !== 8'd198 || cy_flat[DW +: DW] !== 8'd202) begin
                failures++;
                $display("FAIL basic_centroids pass=%0d got cx=%h cy=%h exp c0=(10,10) c1=(198,202)", pass, cx_flat, cy_flat);
            end
            checks++;
            if (cx_flat[2*DW +: DW] !== 8'd50 || cy_flat[2*DW +: DW] !== 8'd60) begin
                failures++;
                $display("FAIL basic_empty_c2 got (%0d,%0d) exp (50,60)", cx_flat[2*DW +: DW], cy_flat[2*DW +: DW]);
            end
            checks++;
            if (converged !== (pass == 2) || iter_count !== 8'(pass)) begin
                failures++;
                $display("FAIL basic_conv_iter pass=%0d got conv=%b iter=%0d exp conv=%0d iter=%0d",
                         pass, converged, iter_count, pass == 2, pass);
            end
        end
    endtask

    task automatic test_round();
        int ex;
`ifdef KMEANS_ROUND_EN
        ex = 4;
`else
        ex = 3;
`endif
        do_sample(3, 0, 0); do_sample(4, 0, 0);
        do_compute();
        checks++;
        if (cx_flat[0 +: DW] !== DW'(ex) || cy_flat[0 +: DW] !== 8'd0) begin
            failures++;
            $display("FAIL round_mean got (%0d,%0d) exp (%0d,0)", cx_flat[0 +: DW], cy_flat[0 +: DW], ex);
        end
    endtask

    task automatic test_collide();
        // valid together with clear_acc: sample is dropped, nothing to average
        valid = 1; px = 8'd250; py = 8'd250; cluster_id = 2'd3; clear_acc = 1;
        tick();
        do_compute();
        checks++;
        if (cx_flat !== exp_cx() || cy_flat !== exp_cy() || converged !== 1'b1) begin
            failures++;
            $display("FAIL collide_clear got cx=%h cy=%h conv=%b exp cx=%h cy=%h conv=1",
                     cx_flat, cy_flat, converged, exp_cx(), exp_cy());
        end
        // valid together with compute_mean: only the earlier sample counts
        do_sample(100, 120, 1);
        valid = 1; px = 8'd0; py = 8'd0; cluster_id = 2'd1; compute_mean = 1;
        tick();
        checks++;
        if (cx_flat[DW +: DW] !== 8'd100 || cy_flat[DW +: DW] !== 8'd120) begin
            failures++;
            $display("FAIL collide_compute got (%0d,%0d) exp (100,120)", cx_flat[DW +: DW], cy_flat[DW +: DW]);
        end
        do_compute();
        checks++;
        if (converged !== 1'b1 || cx_flat[DW +: DW] !== 8'd100) begin
            failures++;
            $display("FAIL collide_acc_cleared got conv=%b c1x=%0d exp conv=1 c1x=100", converged, cx_flat[DW +: DW]);
        end
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < N; n++) do_sample(255, 255, 3);
        do_compute();
        checks++;
        if (cx_flat[3*DW +: DW] !== 8'd255 || cy_flat[3*DW +: DW] !== 8'd255 || acc_ovf !== 1'b0) begin
            failures++;
            $display("FAIL b2b_full got (%0d,%0d) ovf=%b exp (255,255) ovf=0",
                     cx_flat[3*DW +: DW], cy_flat[3*DW +: DW], acc_ovf);
        end
    endtask

    task automatic test_overflow();
        for (int n = 0; n < 256; n++) do_sample($urandom_range(0, 255), $urandom_range(0, 255), 2);
        checks++;
        if (acc_ovf !== 1'b1) begin
            failures++; $display("FAIL ovf_sticky got ovf=%b exp 1", acc_ovf);
        end
        do_compute();
        checks++;
        if (cx_flat !== exp_cx() || cy_flat !== exp_cy() || acc_ovf !== 1'b1) begin
            failures++;
            $display("FAIL ovf_mean got cx=%h cy=%h ovf=%b exp cx=%h cy=%h ovf=1",
                     cx_flat, cy_flat, acc_ovf, exp_cx(), exp_cy());
        end
    endtask

    task automatic test_iter_sat();
        for (int n = 0; n < 260; n++) do_compute();
        checks++;
        if (iter_count !== 8'd255) begin
            failures++; $display("FAIL iter_saturate got %0d exp 255", iter_count);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 2000; c++) begin
            rst          = ($urandom_range(0, 199) == 0);
            init_we      = ($urandom_range(0, 99) < 4);
            compute_mean = ($urandom_range(0, 99) < 8);
            clear_acc    = ($urandom_range(0, 99) < 4);
            valid        = ($urandom_range(0, 99) < 75);
            init_idx     = KW'($urandom); init_x = DW'($urandom); init_y = DW'($urandom);
            cluster_id   = KW'($urandom); px = DW'($urandom); py = DW'($urandom);
            tick();
            checks++;
            if (cx_flat !== exp_cx() || cy_flat !== exp_cy()) begin
                failures++;
                $display("FAIL rand_centroids cyc=%0d got cx=%h cy=%h exp cx=%h cy=%h",
                         c, cx_flat, cy_flat, exp_cx(), exp_cy());
            end
            checks++;
            if (converged !== 1'(m_conv) || iter_count !== 8'(m_iter) || acc_ovf !== 1'(m_ovf)) begin
                failures++;
                $display("FAIL rand_flags cyc=%0d got conv=%b iter=%0d ovf=%b exp conv=%0d iter=%0d ovf=%0d",
                         c, converged, iter_count, acc_ovf, m_conv, m_iter, m_ovf);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_init(1, 77, 88);
        do_sample(5, 6, 1); do_sample(7, 8, 1); do_compute();
        do_sample(9, 9, 1);
        rst = 1;
        tick();
        checks++;
        if (cx_flat !== '0 || cy_flat !== '0 || converged !== 1'b0 || iter_count !== 8'd0 || acc_ovf !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid got cx=%h cy=%h conv=%b iter=%0d ovf=%b exp all 0",
                     cx_flat, cy_flat, converged, iter_count, acc_ovf);
        end
        // Partial sums discarded: a compute right after reset leaves centroids at 0
        do_compute();
        checks++;
        if (cx_flat !== '0 || cy_flat !== '0 || converged !== 1'b1) begin
            failures++;
            $display("FAIL reset_discard got cx=%h cy=%h conv=%b exp 0/0/1", cx_flat, cy_flat, converged);
        end
    endtask

    initial begin
        rst = 0; init_we = 0; valid = 0; compute_mean = 0; clear_acc = 0;
        init_idx = '0; init_x = '0; init_y = '0; px = '0; py = '0; cluster_id = '0;
        for (int i = 0; i < K; i++) begin
            m_cx[i] = 0; m_cy[i] = 0; m_sx[i] = 0; m_sy[i] = 0; m_cnt[i] = 0;
        end
        m_conv = 0; m_iter = 0; m_ovf = 0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_round();
        test_collide();
        test_back_to_back();
        test_overflow();
        test_iter_sat();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
